// File: rtl/alu_seq_if.sv
// Request/result handshake bundle for alu_seq: opcode and operands in,
// registered result and status flags out, each direction with valid/ready.
interface alu_seq_if #(
  parameter int N_BITS    = 8,
  parameter int N_BITS_OP = 6
);
  logic                 i_valid;
  logic                 o_ready;
  logic [N_BITS_OP-1:0] i_operator;
  logic [N_BITS-1:0]    i_data1;
  logic [N_BITS-1:0]    i_data2;
  logic                 o_valid;
  logic                 i_ready;
  logic [N_BITS-1:0]    o_alu;
  logic                 o_zero;
  logic                 o_neg;
  logic                 o_carry;
  logic                 o_ovf;
  logic                 o_err;

  modport slave (
    input  i_valid, i_operator, i_data1, i_data2, i_ready,
    output o_ready, o_valid, o_alu, o_zero, o_neg, o_carry, o_ovf, o_err
  );

  modport master (
    output i_valid, i_operator, i_data1, i_data2, i_ready,
    input  o_ready, o_valid, o_alu, o_zero, o_neg, o_carry, o_ovf, o_err
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle add/sub/logic, iterative one-bit-per-clock shifts,
// result and flags held in DONE until the consumer takes them.
module alu_seq #(
  parameter int N_BITS    = 8,
  parameter int N_BITS_OP = 6,
  parameter int N_BITS_SH = 4
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  alu_seq_if.slave bus
);
  localparam logic [N_BITS_OP-1:0] OP_ADD = N_BITS_OP'(6'b100000);
  localparam logic [N_BITS_OP-1:0] OP_SUB = N_BITS_OP'(6'b100010);
  localparam logic [N_BITS_OP-1:0] OP_AND = N_BITS_OP'(6'b100100);
  localparam logic [N_BITS_OP-1:0] OP_OR  = N_BITS_OP'(6'b100101);
  localparam logic [N_BITS_OP-1:0] OP_XOR = N_BITS_OP'(6'b100110);
  localparam logic [N_BITS_OP-1:0] OP_NOR = N_BITS_OP'(6'b100111);
  localparam logic [N_BITS_OP-1:0] OP_SRL = N_BITS_OP'(6'b000010);
  localparam logic [N_BITS_OP-1:0] OP_SRA = N_BITS_OP'(6'b000011);
  localparam logic [N_BITS_OP-1:0] OP_SLL = N_BITS_OP'(6'b000000);

  localparam int                   MSB     = N_BITS - 1;
  localparam logic [N_BITS:0]      SAT_CMP = (N_BITS + 1)'(N_BITS);
  localparam logic [N_BITS_SH-1:0] SAT_AMT = N_BITS_SH'(N_BITS);
  localparam logic [N_BITS_SH-1:0] ONE_SH  = N_BITS_SH'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  state_t               state_reg, state_next;
  logic [N_BITS_OP-1:0] op_reg;
  logic [N_BITS-1:0]    work_reg;
  logic [N_BITS-1:0]    alu_reg;
  logic [N_BITS_SH-1:0] cnt_reg;
  logic                 zero_reg, neg_reg, carry_reg, ovf_reg, err_reg;

  logic                 accept, is_shift, shift_long, load_result, shift_last;
  logic [N_BITS_SH-1:0] shift_amt;
  logic [N_BITS:0]      sum_ext, diff_ext;
  logic [N_BITS-1:0]    res_calc, shr_val, shl_val, work_shifted;
  logic                 carry_calc, ovf_calc, err_calc, msb_fill;

  assign accept   = bus.i_valid && (state_reg == IDLE);
  assign is_shift = (bus.i_operator == OP_SRL) || (bus.i_operator == OP_SRA) ||
                    (bus.i_operator == OP_SLL);
  // Any amount of N_BITS or more shifts everything out, so clamp it there.
  assign shift_amt   = ({1'b0, bus.i_data2} >= SAT_CMP) ? SAT_AMT : N_BITS_SH'(bus.i_data2);
  assign shift_long  = is_shift && (shift_amt != '0);
  assign load_result = accept && !shift_long;
  assign shift_last  = (cnt_reg == ONE_SH);

  assign sum_ext  = {1'b0, bus.i_data1} + {1'b0, bus.i_data2};
  assign diff_ext = {1'b0, bus.i_data1} - {1'b0, bus.i_data2};

  always_comb begin
    res_calc   = '0;
    carry_calc = 1'b0;
    ovf_calc   = 1'b0;
    err_calc   = 1'b0;
    case (bus.i_operator)
      OP_ADD: begin
        res_calc   = sum_ext[MSB:0];
        carry_calc = sum_ext[N_BITS];
        ovf_calc   = (bus.i_data1[MSB] == bus.i_data2[MSB]) && (sum_ext[MSB] != bus.i_data1[MSB]);
      end
      OP_SUB: begin
        res_calc   = diff_ext[MSB:0];
        carry_calc = diff_ext[N_BITS];
        ovf_calc   = (bus.i_data1[MSB] != bus.i_data2[MSB]) && (diff_ext[MSB] != bus.i_data1[MSB]);
      end
      OP_AND: res_calc = bus.i_data1 & bus.i_data2;
      OP_OR:  res_calc = bus.i_data1 | bus.i_data2;
      OP_XOR: res_calc = bus.i_data1 ^ bus.i_data2;
      OP_NOR: res_calc = ~(bus.i_data1 | bus.i_data2);
      // Only reaches the result register for a zero shift amount.
      OP_SRL, OP_SRA, OP_SLL: res_calc = bus.i_data1;
      default: err_calc = 1'b1;
    endcase
  end

  assign msb_fill = (op_reg == OP_SRA) && work_reg[MSB];

  genvar gi;
  generate
    for (gi = 0; gi < N_BITS; gi++) begin : g_shift
      if (gi == N_BITS - 1) begin : g_top
        assign shr_val[gi] = msb_fill;
      end else begin : g_mid
        assign shr_val[gi] = work_reg[gi+1];
      end
      if (gi == 0) begin : g_bot
        assign shl_val[gi] = 1'b0;
      end else begin : g_up
        assign shl_val[gi] = work_reg[gi-1];
      end
    end
  endgenerate

  assign work_shifted = (op_reg == OP_SLL) ? shl_val : shr_val;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = shift_long ? SHIFT : DONE;
      SHIFT:   if (shift_last) state_next = DONE;
      DONE:    if (bus.i_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.o_ready = (state_reg == IDLE);
    bus.o_valid = (state_reg == DONE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_reg    <= '0;
      work_reg  <= '0;
      cnt_reg   <= '0;
      alu_reg   <= '0;
      zero_reg  <= 1'b0;
      neg_reg   <= 1'b0;
      carry_reg <= 1'b0;
      ovf_reg   <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      if (accept) begin
        op_reg   <= bus.i_operator;
        work_reg <= bus.i_data1;
        cnt_reg  <= shift_amt;
      end
      if (load_result) begin
        alu_reg   <= res_calc;
        zero_reg  <= (res_calc == '0);
        neg_reg   <= res_calc[MSB];
        carry_reg <= carry_calc;
        ovf_reg   <= ovf_calc;
        err_reg   <= err_calc;
      end
      if (state_reg == SHIFT) begin
        work_reg <= work_shifted;
        cnt_reg  <= cnt_reg - ONE_SH;
        if (shift_last) begin
          alu_reg   <= work_shifted;
          zero_reg  <= (work_shifted == '0);
          neg_reg   <= work_shifted[MSB];
          carry_reg <= 1'b0;
          ovf_reg   <= 1'b0;
          err_reg   <= 1'b0;
        end
      end
    end
  end

  assign bus.o_alu   = alu_reg;
  assign bus.o_zero  = zero_reg;
  assign bus.o_neg   = neg_reg;
  assign bus.o_carry = carry_reg;
  assign bus.o_ovf   = ovf_reg;
  assign bus.o_err   = err_reg;
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Sequential, parametrised successor to the combinational ALU. Accepts one operation per transaction over a valid/ready handshake. Add, sub and logic ops complete in one cycle. Shifts run iteratively, one bit per clock. The result is registered and held with status flags (zero, negative, carry/borrow, overflow, error) until the consumer takes it. Sits between the operand/opcode source (UART/command front end) and the result sink in the same datapath.

Parameters:
N_BITS, 8, operand/result width (>=4)
N_BITS_OP, 6, opcode width
N_BITS_SH, 4, shift-counter width; must satisfy 2**N_BITS_SH > N_BITS

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  reset, asynchronous, active-low
i_valid  in  1  request valid
o_ready  out  1  block can accept request
i_operator  in  N_BITS_OP  opcode
i_data1  in  N_BITS  operand A, signed
i_data2  in  N_BITS  operand B, signed; unsigned shift amount for shifts
o_valid  out  1  result valid
i_ready  in  1  consumer accepts result
o_alu  out  N_BITS  result
o_zero  out  1  o_alu == 0
o_neg  out  1  o_alu[N_BITS-1]
o_carry  out  1  ADD carry-out / SUB borrow
o_ovf  out  1  signed overflow (ADD/SUB only)
o_err  out  1  unsupported opcode

Behaviour:
- Clock and reset: one clock i_clk; reset i_rst_n asynchronous, active-low.
- Opcodes:
  - ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111
  - SRL 000010, SRA 000011, SLL 000000 (new)
- Reset (async, any state, including mid-shift):
  - state=IDLE, o_ready=1, o_valid=0.
  - o_alu=0, o_zero=0, o_neg=o_carry=o_ovf=o_err=0, shift counter=0.
  - First accept is possible on the first rising edge after deassertion.
- FSM states: IDLE, SHIFT, DONE.
- o_ready = (state==IDLE). o_valid = (state==DONE). Both are decoded combinationally from state only.
- Accept: i_valid & o_ready at a rising edge. Operands and opcode are captured into internal registers. Inputs are don't-care outside the accept cycle.
- IDLE, accept, non-shift op:
  - Compute into o_alu/flags at the accept edge; go to DONE.
  - o_valid is high the cycle after accept (latency 1).
- IDLE, accept, shift op:
  - k = unsigned i_data2, saturated to N_BITS if >= N_BITS.
  - Load working register with i_data1 and counter with k.
  - If k==0, go directly to DONE with o_alu=i_data1.
  - Otherwise go to SHIFT.
- SHIFT: each cycle, shift the working register by 1 and decrement the counter.
  - SRL inserts 0 at MSB; SRA replicates MSB; SLL inserts 0 at LSB.
  - When the counter reaches 0 on this edge, go to DONE.
  - Total latency accept→o_valid = k+1 cycles. o_ready stays 0 throughout.
- Saturation results: amount >= N_BITS gives SRL/SLL → 0, SRA → all bits equal to the sign bit. Latency is N_BITS+1.
- DONE: o_alu and flags are held stable while i_ready=0 (unlimited backpressure).
  - o_valid & i_ready at an edge → IDLE.
  - No back-to-back accept in the same cycle: o_ready rises the cycle after.
- Arithmetic:
  - ADD/SUB computed at N_BITS+1 width.
  - ADD: o_carry = bit N_BITS of the sum.
  - SUB: o_carry = 1 iff unsigned(A) < unsigned(B).
  - o_ovf: ADD sets it when both operand signs are equal and differ from the result sign. SUB sets it when the operand signs differ and the result sign differs from A.
  - o_carry and o_ovf = 0 for all other ops.
- Flags: o_zero and o_neg are derived from the final registered o_alu for every op. They update together with o_alu.
- Unsupported opcode: takes the normal 1-cycle path; o_alu=0, o_zero=1, o_err=1, other flags 0.
- o_alu and flags change only on an entry into DONE (or on reset). During SHIFT, o_alu holds the previous result.
- Throughput: one transaction per (latency+1) cycles minimum.

Test Plan:
- ADD A=0x7F, B=0x01, accept at cycle T → o_valid at T+1, o_alu=0x80, o_neg=1, o_ovf=1, o_carry=0, o_zero=0.
- SUB A=0x00, B=0x01 → o_alu=0xFF, o_carry=1, o_ovf=0; then ADD 0xFF+0x01 → o_alu=0x00, o_zero=1, o_carry=1.
- SRA A=0x80, B=3 → o_ready=0 for 4 cycles, o_valid exactly 4 cycles after accept, o_alu=0xF0. Also SLL A=0x01, B=7 → 0x80 after 8 cycles.
- Saturation: SRL A=0x80, B=9 → o_alu=0x00 after 9 cycles. SRA A=0x80, B=0x7F → o_alu=0xFF after 9 cycles. Shift B=0 → o_alu=A after 1 cycle.
- Backpressure: hold i_ready=0 for 5 cycles in DONE with i_valid=1 and new operands → o_alu/flags stable, o_ready=0, no capture. Raise i_ready → IDLE, then a new accept is taken.
- Reset and error: assert i_rst_n=0 mid-SHIFT → all outputs zero immediately, before the next edge; after release, o_ready=1. Opcode 0x3F → o_alu=0, o_err=1, o_zero=1.
